// File: rtl/window_pkg.sv
// Shared widths, constants, window coefficients and FSM state for window_apply.
// Build option: WINDOW_TAPER_EN selects the Hann window; undefined gives a rectangular window.
package window_pkg;

   localparam int unsigned SAMPLE_W    = 8;
   localparam int unsigned COEF_W      = 8;
   localparam int unsigned OUT_W       = 16;
   localparam int unsigned NUM_SAMPLES = 8;
   localparam int unsigned IDX_W       = 3;
   localparam int unsigned BUS_W       = NUM_SAMPLES * SAMPLE_W;
   localparam int unsigned DROP_W      = 8;
   localparam int unsigned MID_SCALE   = 128;
   localparam int unsigned CENT_W      = SAMPLE_W + 1;
   localparam int unsigned PROD_W      = CENT_W + COEF_W + 1;

   typedef logic [NUM_SAMPLES-1:0][SAMPLE_W-1:0] frame_t;

`ifdef WINDOW_TAPER_EN
   // Periodic Hann, Q1.7 (128 = 1.0)
   localparam logic [COEF_W-1:0] WINDOW_COEF [NUM_SAMPLES] =
      '{8'd0, 8'd19, 8'd64, 8'd109, 8'd128, 8'd109, 8'd64, 8'd19};
`else
   // Rectangular, unity gain in Q1.7
   localparam logic [COEF_W-1:0] WINDOW_COEF [NUM_SAMPLES] =
      '{8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128};
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_e;

   // Remove the mid-scale offset: 0..255 -> -128..127
   function automatic logic signed [CENT_W-1:0] center_sample(input logic [SAMPLE_W-1:0] s);
      return $signed({1'b0, s}) - $signed(CENT_W'(MID_SCALE));
   endfunction

endpackage

// File: rtl/window_apply_if.sv
// Output stream of windowed samples with valid/ready handshake.
interface window_apply_if;
   import window_pkg::*;

   logic signed [OUT_W-1:0] out_sample;
   logic [IDX_W-1:0]        out_index;
   logic                    out_last;
   logic                    out_valid;
   logic                    out_ready;

   modport master (
      output out_sample,
      output out_index,
      output out_last,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_sample,
      input  out_index,
      input  out_last,
      input  out_valid,
      output out_ready
   );

endinterface

// File: rtl/set_sync.sv
// Two-flop synchronizer for the packer's asynchronous set level plus rising-edge detect.
// All flops reset to 0, so a level already high at reset release reads as an edge.
module set_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic start_c
);

   logic s1_q, s2_q, s3_q;
   logic s1_d, s2_d, s3_d;

   // Next-state of the synchronizer chain and history flop
   always_comb begin
      s1_d = async_in;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   // Synchronizer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign start_c = s2_q & ~s3_q;

endmodule

// File: rtl/window_apply.sv
// Captures an 8-sample frame on each set edge, removes mid-scale, applies the
// window and streams the eight products over a valid/ready handshake.
// Build option: WINDOW_TAPER_EN (Hann window); undefined gives rectangular window.
module window_apply
   import window_pkg::*;
(
   input  logic                fastclk,
   input  logic                rst_n,
   input  logic [BUS_W-1:0]    in_bus,
   input  logic                set,
   window_apply_if.master      win,
   output logic                overrun,
   output logic [DROP_W-1:0]   drop_cnt
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

   logic start_c;

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   frame_t                  frame_q, frame_d;
   logic signed [OUT_W-1:0] out_sample_q, out_sample_d;
   logic [IDX_W-1:0]        out_index_q, out_index_d;
   logic                    out_last_q, out_last_d;
   logic                    out_valid_q, out_valid_d;
   logic                    overrun_q, overrun_d;
   logic [DROP_W-1:0]       drop_cnt_q, drop_cnt_d;

   logic signed [CENT_W-1:0] centered_c;
   logic [COEF_W-1:0]        coef_c;
   logic signed [PROD_W-1:0] product_c;
   logic                     drop_c;

   set_sync u_set_sync (
      .clk      (fastclk),
      .rst_n    (rst_n),
      .async_in (set),
      .start_c  (start_c)
   );

   // Windowed product of the current sample; exact, fits OUT_W
   always_comb begin
      centered_c = center_sample(frame_q[idx_q]);
`ifdef WINDOW_TAPER_EN
      coef_c     = WINDOW_COEF[idx_q];
`else
      coef_c     = WINDOW_COEF[0];
`endif
      product_c  = PROD_W'(centered_c) * PROD_W'($signed({1'b0, coef_c}));
   end

   // Frame FSM next-state, output and drop-counter logic
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      frame_d      = frame_q;
      out_sample_d = out_sample_q;
      out_index_d  = out_index_q;
      out_last_d   = out_last_q;
      out_valid_d  = out_valid_q;
      overrun_d    = 1'b0;
      drop_cnt_d   = drop_cnt_q;
      drop_c       = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_c) begin
               frame_d = in_bus;
               idx_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            out_sample_d = product_c[OUT_W-1:0];
            out_index_d  = idx_q;
            out_last_d   = (idx_q == LAST_IDX);
            out_valid_d  = 1'b1;
            state_d      = HOLD;
            drop_c       = start_c;
         end
         HOLD: begin
            if (win.out_ready) begin
               out_valid_d = 1'b0;
               if (idx_q == LAST_IDX) begin
                  // A new frame arriving with the final accept chains straight in
                  if (start_c) begin
                     frame_d = in_bus;
                     idx_d   = '0;
                     state_d = CALC;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = CALC;
                  drop_c  = start_c;
               end
            end else begin
               drop_c = start_c;
            end
         end
         default: state_d = IDLE;
      endcase

      if (drop_c) begin
         overrun_d = 1'b1;
         if (drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + DROP_W'(1);
         end
      end
   end

   // State and output registers
   always_ff @(posedge fastclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         frame_q      <= '0;
         out_sample_q <= '0;
         out_index_q  <= '0;
         out_last_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         overrun_q    <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         frame_q      <= frame_d;
         out_sample_q <= out_sample_d;
         out_index_q  <= out_index_d;
         out_last_q   <= out_last_d;
         out_valid_q  <= out_valid_d;
         overrun_q    <= overrun_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign win.out_sample = out_sample_q;
   assign win.out_index  = out_index_q;
   assign win.out_last   = out_last_q;
   assign win.out_valid  = out_valid_q;
   assign overrun        = overrun_q;
   assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_window_apply.sv
// Scoreboard bench for window_apply: stimulus pushes expected samples,
// a negedge monitor pops and compares on every transfer.
module tb_window_apply;

`ifdef WINDOW_TAPER_EN
   localparam int COEF_TAB [8] = '{0, 19, 64, 109, 128, 109, 64, 19};
`else
   localparam int COEF_TAB [8] = '{128, 128, 128, 128, 128, 128, 128, 128};
`endif

   typedef struct {
      int sample;
      int index;
      int last;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [63:0] in_bus;
   logic        set;
   logic        overrun;
   logic [7:0]  drop_cnt;

   int total;
   int bad;
   exp_t exp_q [$];

   window_apply_if win ();

   window_apply dut (
      .fastclk  (clk),
      .rst_n    (rst_n),
      .in_bus   (in_bus),
      .set      (set),
      .win      (win),
      .overrun  (overrun),
      .drop_cnt (drop_cnt)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
      $fatal(1, "watchdog");
   end

   function automatic int exp_val(input logic [7:0] b, input int k);
      return (int'(b) - 128) * COEF_TAB[k];
   endfunction

   task automatic check(input string name, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic push_frame(input logic [63:0] bus);
      exp_t e;
      for (int k = 0; k < 8; k++) begin
         e.sample = exp_val(bus[8*k +: 8], k);
         e.index  = k;
         e.last   = (k == 7) ? 1 : 0;
         exp_q.push_back(e);
      end
   endtask

   // Monitor: pop and compare on each transfer
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && win.out_valid && win.out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got index %0d sample %0d, expected no output",
                     win.out_index, win.out_sample);
         end else begin
            e = exp_q.pop_front();
            check("sample", int'(win.out_sample), e.sample);
            check("index", int'(win.out_index), e.index);
            check("last", int'(win.out_last), e.last);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!win.out_valid && n < 40) begin
         tick();
         n++;
      end
      if (!win.out_valid) begin
         total++;
         bad++;
         $display("FAIL wait_valid: got out_valid=0 after %0d cycles, expected 1", n);
      end
   endtask

   task automatic pulse_set();
      set = 1'b1;
      repeat (3) tick();
      set = 1'b0;
   endtask

   // With out_ready low, advance one accept at a time until the target index is presented
   task automatic step_to(input int target);
      int guard;
      guard = 0;
      wait_valid();
      while (int'(win.out_index) != target && guard < 10) begin
         win.out_ready = 1'b1;
         tick();
         win.out_ready = 1'b0;
         wait_valid();
         guard++;
      end
      check("step_index", int'(win.out_index), target);
   endtask

   task automatic drain();
      int n;
      n = 0;
      win.out_ready = 1'b1;
      while ((exp_q.size() != 0 || win.out_valid) && n < 200) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d samples outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) tick();
   endtask

   initial begin
      int n;
      int ov;
      logic [63:0] bus_a;

      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      set   = 1'b0;
      in_bus = '0;
      win.out_ready = 1'b0;

      // Reset state
      repeat (3) tick();
      check("rst_valid", int'(win.out_valid), 0);
      check("rst_sample", int'(win.out_sample), 0);
      check("rst_drop", int'(drop_cnt), 0);
      check("rst_overrun", int'(overrun), 0);
      rst_n = 1'b1;
      repeat (2) tick();

      // All 0xFF, ready high, first-valid latency
      in_bus = {8{8'hFF}};
      win.out_ready = 1'b1;
      push_frame(in_bus);
      set = 1'b1;
      n = 0;
      while (!win.out_valid && n < 20) begin
         tick();
         n++;
      end
      check("first_valid_latency", n, 4);
      set = 1'b0;
      drain();

      // All 0x00
      in_bus = {8{8'h00}};
      push_frame(in_bus);
      pulse_set();
      drain();

      // Backpressure at idx 3
      win.out_ready = 1'b0;
      in_bus = {8{8'hFF}};
      push_frame(in_bus);
      pulse_set();
      step_to(3);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_sample", int'(win.out_sample), exp_val(8'hFF, 3));
         check("bp_index", int'(win.out_index), 3);
         check("bp_valid", int'(win.out_valid), 1);
      end
      win.out_ready = 1'b1;
      tick();
      win.out_ready = 1'b0;
      check("bp_gap_valid", int'(win.out_valid), 0);
      tick();
      check("bp_next_valid", int'(win.out_valid), 1);
      check("bp_next_index", int'(win.out_index), 4);
      drain();

      // Overrun at idx 2; current frame continues
      bus_a = 64'hF0E0D0C0B0A09080;
      win.out_ready = 1'b0;
      in_bus = bus_a;
      push_frame(bus_a);
      pulse_set();
      step_to(2);
      in_bus = {8{8'h11}};
      set = 1'b1;
      ov = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (overrun) ov++;
      end
      set = 1'b0;
      check("overrun_pulse_cycles", ov, 1);
      check("drop_cnt_one", int'(drop_cnt), 1);
      check("ovr_index_kept", int'(win.out_index), 2);
      check("ovr_sample_kept", int'(win.out_sample), exp_val(8'hA0, 2));

      // 256 further drops saturate the counter
      for (int i = 0; i < 256; i++) begin
         set = 1'b1;
         repeat (3) tick();
         set = 1'b0;
         repeat (3) tick();
      end
      repeat (3) tick();
      check("drop_cnt_sat", int'(drop_cnt), 255);
      drain();

      // Reset mid-frame at idx 5
      win.out_ready = 1'b0;
      in_bus = 64'h0123456789ABCDEF;
      push_frame(in_bus);
      pulse_set();
      step_to(5);
      rst_n = 1'b0;
      #1;
      check("mid_rst_sample", int'(win.out_sample), 0);
      check("mid_rst_index", int'(win.out_index), 0);
      check("mid_rst_last", int'(win.out_last), 0);
      check("mid_rst_valid", int'(win.out_valid), 0);
      check("mid_rst_overrun", int'(overrun), 0);
      check("mid_rst_drop", int'(drop_cnt), 0);
      exp_q.delete();
      in_bus = 64'h00FF7F80C0401020;
      set = 1'b1;
      repeat (2) tick();
      rst_n = 1'b1;
      push_frame(in_bus);
      drain();
      set = 1'b0;
      repeat (3) tick();

      // Offset boundaries: 0x80 -> 0, 0xC0, 0x00
      in_bus = 64'hA540FE017F00C080;
      push_frame(in_bus);
      pulse_set();
      drain();

      // New frame arriving with the idx-7 accept is not an overrun
      win.out_ready = 1'b0;
      in_bus = {8{8'h40}};
      push_frame(in_bus);
      pulse_set();
      step_to(7);
      in_bus = 64'h102030405060708F;
      set = 1'b1;
      tick();
      tick();
      win.out_ready = 1'b1;
      push_frame(in_bus);
      ov = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (overrun) ov++;
      end
      check("chain_no_overrun", ov, 0);
      check("chain_drop_cnt", int'(drop_cnt), 0);
      drain();
      set = 1'b0;
      repeat (3) tick();

      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
